// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// The division datapath is present only when ALU_MULDIV_DIV_EN is defined.
package alu_muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] SUB = 4'b1000;
  localparam logic [3:0] SLT = 4'b0010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_muldiv_stepcnt.sv
// Iteration counter for the multiply/divide unit: clear on accept,
// count while running, flag the final step.
module alu_muldiv_stepcnt
  import alu_muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic last
);

  logic [4:0] cnt_r;

  // step counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= 5'd0;
    end else if (clear) begin
      cnt_r <= 5'd0;
    end else if (en) begin
      cnt_r <= cnt_r + 5'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == 5'(ITER - 1));

endmodule

// File: rtl/alu_muldiv_seq.sv
// Sequential unsigned MUL/MULHU/DIVU/REMU borrowing a shared external ALU,
// one bit per cycle. Define ALU_MULDIV_DIV_EN to build the division datapath.
module alu_muldiv_seq
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             alu_busy,
  output logic [WIDTH-1:0] alu_srca,
  output logic [WIDTH-1:0] alu_srcb,
  output logic [3:0]       alu_alucontrol,
  input  logic [WIDTH-1:0] alu_aluout
);

  state_e           state_r, state_n;
  op_e              op_r;
  logic [WIDTH-1:0] opnd_r, hi_r, lo_r, result_r;
  logic [WIDTH-1:0] hi_n_s, lo_n_s, fast_result_s;
  logic [WIDTH-1:0] alu_srca_s, alu_srcb_s;
  logic [3:0]       alu_ctl_s;
  logic             accept_s, fast_s, last_s, carry_s;
`ifdef ALU_MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh_s;
`endif

  assign accept_s = in_valid && (state_r == IDLE);

  alu_muldiv_stepcnt u_stepcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (accept_s),
    .en      (state_r == RUN),
    .last    (last_s)
  );

  // requests that complete without iterating (divide by zero, or no divider)
  always_comb begin
    fast_s        = 1'b0;
    fast_result_s = {WIDTH{1'b1}};
`ifdef ALU_MULDIV_DIV_EN
    if (op[1] && (srcb == {WIDTH{1'b0}})) begin
      fast_s = 1'b1;
      if (op[0]) begin
        fast_result_s = srca;
      end else begin
        fast_result_s = {WIDTH{1'b1}};
      end
    end else begin
      fast_s = 1'b0;
    end
`else
    if (op[1]) begin
      fast_s = 1'b1;
    end else begin
      fast_s = 1'b0;
    end
`endif
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // next-state logic
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_n = fast_s ? DONE : RUN;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_n = DONE;
        end else begin
          state_n = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // one iteration step: ALU operand drive and next accumulator values
  always_comb begin
    alu_srca_s = {WIDTH{1'b0}};
    alu_srcb_s = {WIDTH{1'b0}};
    alu_ctl_s  = ADD;
    hi_n_s     = hi_r;
    lo_n_s     = lo_r;
    carry_s    = 1'b0;
`ifdef ALU_MULDIV_DIV_EN
    rem_sh_s   = {hi_r, lo_r[WIDTH-1]};
`endif
    if (state_r == RUN) begin
      if (op_r[1]) begin
`ifdef ALU_MULDIV_DIV_EN
        // hi holds the remainder, lo shifts dividend bits out and quotient bits in
        alu_srca_s = rem_sh_s[WIDTH-1:0];
        alu_srcb_s = opnd_r;
        alu_ctl_s  = SUB;
        if (rem_sh_s >= {1'b0, opnd_r}) begin
          hi_n_s = alu_aluout;
          lo_n_s = {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          hi_n_s = rem_sh_s[WIDTH-1:0];
          lo_n_s = {lo_r[WIDTH-2:0], 1'b0};
        end
`else
        hi_n_s = hi_r;
        lo_n_s = lo_r;
`endif
      end else begin
        alu_srca_s = hi_r;
        alu_srcb_s = opnd_r;
        alu_ctl_s  = ADD;
        if (lo_r[0]) begin
          carry_s = (alu_aluout < hi_r);
          hi_n_s  = {carry_s, alu_aluout[WIDTH-1:1]};
          lo_n_s  = {alu_aluout[0], lo_r[WIDTH-1:1]};
        end else begin
          hi_n_s  = {1'b0, hi_r[WIDTH-1:1]};
          lo_n_s  = {hi_r[0], lo_r[WIDTH-1:1]};
        end
      end
    end else begin
      alu_ctl_s = ADD;
    end
  end

  // operand capture, accumulators and result register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_r     <= OP_MUL;
      opnd_r   <= {WIDTH{1'b0}};
      hi_r     <= {WIDTH{1'b0}};
      lo_r     <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      op_r <= op_e'(op);
      hi_r <= {WIDTH{1'b0}};
      if (op[1]) begin
        opnd_r <= srcb;
        lo_r   <= srca;
      end else begin
        opnd_r <= srca;
        lo_r   <= srcb;
      end
      if (fast_s) begin
        result_r <= fast_result_s;
      end else begin
        result_r <= result_r;
      end
    end else if (state_r == RUN) begin
      hi_r <= hi_n_s;
      lo_r <= lo_n_s;
      // odd opcodes (MULHU, REMU) take the high half
      if (last_s) begin
        result_r <= op_r[0] ? hi_n_s : lo_n_s;
      end else begin
        result_r <= result_r;
      end
    end else begin
      result_r <= result_r;
    end
  end

  assign in_ready       = (state_r == IDLE);
  assign out_valid      = (state_r == DONE);
  assign alu_busy       = (state_r == RUN);
  assign result         = result_r;
  assign alu_srca       = alu_srca_s;
  assign alu_srcb       = alu_srcb_s;
  assign alu_alucontrol = alu_ctl_s;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed table, random ops against
// a plain-arithmetic model, backpressure and mid-operation reset sequences.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] srca = 32'd0;
  logic [31:0] srcb = 32'd0;
  logic        in_ready, out_valid, alu_busy;
  logic [31:0] result, alu_srca, alu_srcb, alu_aluout;
  logic [3:0]  alu_alucontrol;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  // reference adder/subtractor standing in for the shared ALU
  assign alu_aluout = (alu_alucontrol == 4'b1000) ? (alu_srca - alu_srcb) : (alu_srca + alu_srcb);

  alu_muldiv_seq #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op             (op),
    .srca           (srca),
    .srcb           (srcb),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .alu_busy       (alu_busy),
    .alu_srca       (alu_srca),
    .alu_srcb       (alu_srcb),
    .alu_alucontrol (alu_alucontrol),
    .alu_aluout     (alu_aluout)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (o)
      2'b00: return p[31:0];
      2'b01: return p[63:32];
`ifdef ALU_MULDIV_DIV_EN
      2'b10: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'd0) ? a : a % b;
`else
      default: return 32'hFFFF_FFFF;
`endif
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef ALU_MULDIV_DIV_EN
    return (o[1] && b == 32'd0) ? 1 : 33;
`else
    return o[1] ? 1 : 33;
`endif
  endfunction

  // caller is at a falling edge; returns at a falling edge after the handshake
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k;
    int w;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check({name, " ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, " latency"}, 32'(k), 32'(lat));
    check({name, " result"}, result, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int k;
    int seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b00, 32'd7, 32'd6, 32'd42, 33};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33};
    vecs[5]  = '{2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[7]  = '{2'b00, 32'd0, 32'h1234_5678, 32'd0, 33};
    vecs[8]  = '{2'b01, 32'h8000_0000, 32'd2, 32'd1, 33};
`ifdef ALU_MULDIV_DIV_EN
    vecs[3]  = '{2'b10, 32'd100, 32'd7, 32'd14, 33};
    vecs[4]  = '{2'b11, 32'd100, 32'd7, 32'd2, 33};
    vecs[6]  = '{2'b11, 32'd5, 32'd0, 32'd5, 1};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33};
    vecs[10] = '{2'b11, 32'd7, 32'd100, 32'd7, 33};
`else
    vecs[3]  = '{2'b10, 32'd100, 32'd7, 32'hFFFF_FFFF, 1};
    vecs[4]  = '{2'b11, 32'd100, 32'd7, 32'hFFFF_FFFF, 1};
    vecs[6]  = '{2'b11, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1};
    vecs[10] = '{2'b11, 32'd7, 32'd100, 32'hFFFF_FFFF, 1};
`endif

    // reset state
    repeat (3) @(negedge clk);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst result", result, 32'd0);
    check("rst alu_busy", {31'd0, alu_busy}, 32'd0);
    check("rst alu_srca", alu_srca, 32'd0);
    check("rst alu_srcb", alu_srcb, 32'd0);
    check("rst alu_ctl", {28'd0, alu_alucontrol}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);

    // ALU ownership while running
    in_valid = 1'b1; op = 2'b00; srca = 32'd9; srcb = 32'd3;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("run alu_busy", {31'd0, alu_busy}, 32'd1);
    check("run in_ready", {31'd0, in_ready}, 32'd0);
    k = 2;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("run latency", 32'(k), 32'd33);
    check("run result", result, 32'd27);
    check("done alu_srca", alu_srca, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 1) ra = ra >> $urandom_range(0, 31);
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb,
             model_res(ro, ra, rb), model_lat(ro, rb));
    end

    // backpressure: result held, new requests ignored
    in_valid = 1'b1; op = 2'b00; srca = 32'd7; srcb = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp latency", 32'(k), 32'd33);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp result %0d", i), result, 32'd42);
      check($sformatf("bp in_ready %0d", i), {31'd0, in_ready}, 32'd0);
      check($sformatf("bp out_valid %0d", i), {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1; op = 2'b01; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp in_ready after", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || alu_busy) seen++;
    end
    check("bp ignored request", 32'(seen), 32'd0);

    // reset in the middle of a multiply
    in_valid = 1'b1; op = 2'b01; srca = 32'hDEAD_BEEF; srcb = 32'hFFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid alu_busy before", {31'd0, alu_busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid out_valid", {31'd0, out_valid}, 32'd0);
    check("mid alu_busy", {31'd0, alu_busy}, 32'd0);
    check("mid alu_srca", alu_srca, 32'd0);
    check("mid result", result, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("mid in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid discarded", 32'(seen), 32'd0);
    run_op("mid mul 3*3", 2'b00, 32'd3, 32'd3, 32'd9, 33);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
ALU_MULDIV_SEQ -- requirements
Module: alu_muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  2  operation: 00 MUL (low word), 01 MULHU (high word), 10 DIVU, 11 REMU; all operations are unsigned.
REQ-007 srca  input  32  first operand: multiplicand or dividend.
REQ-008 srcb  input  32  second operand: multiplier or divisor.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  32  operation result.
REQ-012 alu_busy  output  1  block owns the shared ALU; the datapath mux selects the alu_* ports while this is high.
REQ-013 alu_srca  output  32  ALU operand A.
REQ-014 alu_srcb  output  32  ALU operand B.
REQ-015 alu_alucontrol  output  4  ALU opcode: add 4'b0000, sub 4'b1000.
REQ-016 alu_aluout  input  32  ALU result, combinational, same cycle.

Function
REQ-017 States: IDLE, RUN, DONE.
- in_ready is 1 only in IDLE.
- alu_busy is 1 only in RUN.
REQ-018 Accept in cycle T when in_valid and in_ready are both 1: latch op and operands, clear the 5-bit step counter, enter RUN.
REQ-019 RUN lasts exactly 32 cycles (counter 0..31); on counter 31 enter DONE, so out_valid rises at T+33.
REQ-020 MUL/MULHU step: shift-add over a 64-bit {hi,lo} accumulator.
- If the multiplier LSB is 1: alu_srca=hi, alu_srcb=multiplicand, alucontrol=add.
- Carry-out is computed locally as (alu_aluout < alu_srca), unsigned.
- Shift {carry, sum/hi, lo} right by one bit.
REQ-021 DIVU/REMU step: restoring division.
- Shift the 33-bit remainder left and bring in the next dividend bit.
- alu_srca=rem[31:0], alu_srcb=divisor, alucontrol=sub.
- If the local 33-bit compare shows rem >= divisor, take alu_aluout as the new remainder and shift in quotient bit 1; otherwise keep the remainder and shift in 0.
REQ-022 Outside RUN, alu_srca, alu_srcb and alu_alucontrol are all 0.
REQ-023 Divide by zero (op 1x, srcb==0): go IDLE->DONE directly with out_valid at T+1.
- DIVU result = 32'hFFFF_FFFF.
- REMU result = srca.
REQ-024 In DONE: out_valid=1 and result is held stable until out_ready=1; on that handshake cycle go to IDLE, so in_ready=1 in the following cycle.
REQ-025 in_valid while not in IDLE is ignored; the operands are not sampled.
REQ-026 Results wrap modulo 2^32.
- MUL returns the low word and MULHU the high word of the 64-bit product.
- DIVU returns the quotient and REMU the remainder.

Reset
REQ-027 reset_n low forces IDLE at once and clears the counter, accumulators and all outputs: in_ready=1 after release, out_valid=0, result=0, alu_busy=0, alu_* outputs=0.
REQ-028 Reset during RUN or DONE discards the operation; no result is produced.

Configuration
REQ-029 Macro ALU_MULDIV_DIV_EN defined: DIVU/REMU behave as in REQ-021 and REQ-023.
REQ-030 Macro ALU_MULDIV_DIV_EN undefined: the division datapath is absent; DIVU/REMU go IDLE->DONE with result=32'hFFFF_FFFF at T+1; MUL/MULHU are unchanged.

Structure
REQ-031 Package alu_muldiv_pkg holds:
- the op encodings;
- the ALU opcode constants ADD=4'b0000, SUB=4'b1000, SLT=4'b0010;
- the state enum;
- ITER=32.
REQ-032 One sub-module, alu_muldiv_stepcnt, provides the 5-bit step counter with clear, enable and last-step flag.
REQ-033 The ALU itself is external and shared; this block does not instantiate it.

Verification (bench connects a reference adder/subtractor to the alu_* ports)
REQ-034 MUL 7*6: accepted at T -> out_valid at T+33, result=42.
REQ-035 MULHU 32'hFFFF_FFFF * 32'hFFFF_FFFF -> result=32'hFFFF_FFFE; MUL with the same operands -> result=1.
REQ-036 DIVU 100/7 -> result=14; REMU 100/7 -> result=2; both at T+33 (with ALU_MULDIV_DIV_EN defined).
REQ-037 Divide by zero:
- DIVU 5/0 -> result=32'hFFFF_FFFF at T+1.
- REMU 5/0 -> result=5.
- Without ALU_MULDIV_DIV_EN, DIVU 100/7 -> result=32'hFFFF_FFFF at T+1.
REQ-038 Backpressure: hold out_ready low for 5 cycles -> result stable and in_ready=0 throughout; a new in_valid during DONE is ignored.
REQ-039 Mid-operation reset: assert reset_n low at step 10 -> out_valid=0 and alu_busy=0 immediately, in_ready=1 after release; the next MUL 3*3 -> result=9.
